// File: rtl/core_pkg.sv
// Shared RV32 core definitions: datapath widths, ALU opcodes and the
// control bundle carried from decode into execute.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_imm;
    logic [2:0] alu_ctrl;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding select: EX/MEM result beats MEM/WB result,
// which beats the stored register value. Combinational; x0 always reads zero.
module fwd_mux
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [XLEN-1:0]       stored_dat,
  input  logic                  mem_fwd_en,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]       mem_fwd_dat,
  input  logic                  wb_fwd_en,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_dat,
  output logic [XLEN-1:0]       fwd_dat
);

  always_comb begin
    fwd_dat = stored_dat;
    if (rs == '0) begin
      fwd_dat = '0;
    end else if (mem_fwd_en && (mem_fwd_rd == rs)) begin
      fwd_dat = mem_fwd_dat;
    end else if (wb_fwd_en && (wb_fwd_rd == rs)) begin
      fwd_dat = wb_fwd_dat;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall; one cycle latency.
// Holds all fields while out_ready is low, refreshing source data from forwarding each cycle.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [2:0]            in_alu_ctrl,
  input  logic                  in_alu_src_imm,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  mem_fwd_en,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic                  wb_fwd_en,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_a,
  output logic [XLEN-1:0]       out_b,
  output logic [2:0]            out_alu_ctrl,
  output logic [XLEN-1:0]       out_store_data,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write
);

  logic                  valid_q, valid_d;
  id_ex_ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic [XLEN-1:0]       rs1_dat_q, rs1_dat_d;
  logic [XLEN-1:0]       rs2_dat_q, rs2_dat_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  id_ex_ctrl_t           in_ctrl;
  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;
  logic                  load_use;
  logic                  advance;
  logic                  accept;

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs          (rs1_q),
    .stored_dat  (rs1_dat_q),
    .mem_fwd_en  (mem_fwd_en),
    .mem_fwd_rd  (mem_fwd_rd),
    .mem_fwd_dat (mem_fwd_data),
    .wb_fwd_en   (wb_fwd_en),
    .wb_fwd_rd   (wb_fwd_rd),
    .wb_fwd_dat  (wb_fwd_data),
    .fwd_dat     (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs          (rs2_q),
    .stored_dat  (rs2_dat_q),
    .mem_fwd_en  (mem_fwd_en),
    .mem_fwd_rd  (mem_fwd_rd),
    .mem_fwd_dat (mem_fwd_data),
    .wb_fwd_en   (wb_fwd_en),
    .wb_fwd_rd   (wb_fwd_rd),
    .wb_fwd_dat  (wb_fwd_data),
    .fwd_dat     (fwd_rs2)
  );

  // Both sources are compared even when the consumer ignores rs2 (imm forms).
  always_comb begin
    load_use = valid_q && ctrl_q.mem_read && (rd_q != '0) && in_valid &&
               ((in_rs1 == rd_q) || (in_rs2 == rd_q));
    advance  = !valid_q || out_ready;
    in_ready = flush || (advance && !load_use);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    in_ctrl             = CTRL_NOP;
    in_ctrl.reg_write   = in_reg_write;
    in_ctrl.mem_read    = in_mem_read;
    in_ctrl.mem_write   = in_mem_write;
    in_ctrl.alu_src_imm = in_alu_src_imm;
    in_ctrl.alu_ctrl    = in_alu_ctrl;
  end

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rs1_dat_d = rs1_dat_q;
    rs2_dat_d = rs2_dat_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (accept) begin
      valid_d   = 1'b1;
      ctrl_d    = in_ctrl;
      pc_d      = in_pc;
      imm_d     = in_imm;
      rs1_dat_d = in_rs1_data;
      rs2_dat_d = in_rs2_data;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      rd_d      = in_rd;
    end else if (advance) begin
      // Drained with nothing accepted (idle or load-use bubble).
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else begin
      // Stalled: capture late writebacks so they survive past their one-cycle pulse.
      rs1_dat_d = fwd_rs1;
      rs2_dat_d = fwd_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      pc_q      <= '0;
      imm_q     <= '0;
      rs1_dat_q <= '0;
      rs2_dat_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rs1_dat_q <= rs1_dat_d;
      rs2_dat_q <= rs2_dat_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_a          = fwd_rs1;
  assign out_b          = ctrl_q.alu_src_imm ? imm_q : fwd_rs2;
  assign out_store_data = fwd_rs2;
  assign out_alu_ctrl   = ctrl_q.alu_ctrl;
  assign out_pc         = pc_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the RV32 core.
- Registers one decoded instruction per cycle, resolves data hazards by forwarding and load-use stalling, and drives the ALU operand inputs `a`, `b` and `ALUControl`.
- Sits between the decoder/register file (upstream) and the ALU plus EX/MEM register (downstream).
- Uses a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2  in  REG_ADDR_W  source register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_rd  in  REG_ADDR_W  destination index
- in_alu_ctrl  in  3  ALU operation code (000 add … 111 slt)
- in_alu_src_imm  in  1  1: operand b = immediate
- in_reg_write, in_mem_read, in_mem_write  in  1 each  control bits
- mem_fwd_en  in  1  EX/MEM holds a register write
- mem_fwd_rd  in  REG_ADDR_W  its destination
- mem_fwd_data  in  XLEN  its result
- wb_fwd_en, wb_fwd_rd, wb_fwd_data  in  1/REG_ADDR_W/XLEN  same, for MEM/WB
- flush  in  1  kill held and incoming instruction (branch redirect)
- out_valid  out  1  registered instruction valid
- out_ready  in  1  downstream accepts
- out_a, out_b  out  XLEN  ALU operands
- out_alu_ctrl  out  3  ALU operation code
- out_store_data  out  XLEN  forwarded rs2 value
- out_pc  out  XLEN  registered PC
- out_rd  out  REG_ADDR_W  registered destination
- out_reg_write, out_mem_read, out_mem_write  out  1 each  registered control bits; qualified by out_valid

Behaviour:
- Reset (rst=1 at edge): every register cleared. out_valid=0, all control bits 0, all indices/data/PC 0. in_ready combinationally 1 while out_valid=0 and no hazard.
- Latency: an instruction accepted at edge N is presented with out_valid=1 in cycle N+1.
- Handshake:
  - Transfer in = in_valid & in_ready.
  - Transfer out = out_valid & out_ready.
  - in_ready = (!out_valid | out_ready) & !load_use.
- load_use = out_valid & out_mem_read & out_rd≠0 & in_valid & (in_rs1==out_rd | in_rs2==out_rd). Conservative: both sources are always compared.
- On load_use with out_ready=1: the register loads a bubble (out_valid=0, control bits 0). The upstream instruction is held and re-accepted next cycle.
- Held state (out_valid & !out_ready): all fields keep their values. The stored rs1/rs2 data is refreshed each cycle with the forwarded value, so a WB result that retires during the stall is not lost.
- Forwarding (combinational, per source, on registered rs1/rs2):
  - mem_fwd_en & mem_fwd_rd==rs & rs≠0 → mem_fwd_data.
  - else wb_fwd_en & wb_fwd_rd==rs & rs≠0 → wb_fwd_data.
  - else stored data.
  - MEM has priority over WB. x0 is never forwarded and always reads 0.
- out_a = fwd_rs1.
- out_b = in_alu_src_imm (registered) ? imm : fwd_rs2.
- out_store_data = fwd_rs2 regardless of alu_src_imm.
- flush (highest priority after rst): next edge out_valid=0 and control bits 0. in_ready=1 during the flush cycle; any input is consumed and discarded. flush with out_valid=0 is harmless.
- Simultaneous transfer out and in: the new instruction replaces the old in the same edge, with no bubble.
- No arithmetic in this stage; widths pass unchanged.

Decomposition:
- Shared package core_pkg:
  - ALU opcode constants (ALU_ADD=3'b000 … ALU_SLT=3'b111).
  - XLEN, REG_ADDR_W.
  - Packed id_ex_ctrl_t: reg_write, mem_read, mem_write, alu_src_imm, alu_ctrl.
- One sub-module, fwd_mux: a per-source forwarding select, instantiated twice (rs1, rs2).

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_a=out_b=0, in_ready=1 after release; first accepted instruction (addi x1,x0,5) gives out_b=5, out_alu_ctrl=000 one cycle later.
- Forward priority: registered rs1=x3, stored 0x11; mem_fwd(x3,0xAA) and wb_fwd(x3,0xBB) both enabled → out_a=0xAA; drop mem_fwd_en → out_a=0xBB; rs1=x0 with both forwards targeting x0 → out_a=0.
- Load-use: held lw x5 (out_valid=1, out_ready=1); incoming add x6,x5,x7 → in_ready=0 one cycle, next cycle out_valid=0 bubble, following cycle add accepted; no instruction lost or duplicated.
- Backpressure refresh: out_ready=0 for 3 cycles, wb_fwd(x2,0x1234) pulses in cycle 1 only, held rs2=x2 → out_store_data=0x1234 in cycles 2–3 and at release.
- Flush: flush=1 with out_valid=1 and in_valid=1 → next cycle out_valid=0, out_reg_write=0, and the input is not presented afterwards.
- Throughput: 8 back-to-back independent instructions, out_ready=1 → one out_valid per cycle, in order, PCs 0x0..0x1C.
